// File: rtl/iexu_dispatch.sv
// Integer execution unit dispatch: decodes RV32I OP/OP-IMM ALU instructions
// into iexu_conf operations and queues them for the IEXU behind a small FIFO.

package constants;
    typedef logic [2:0] iexu_conf;
    localparam iexu_conf add_conf = 3'd0;
    localparam iexu_conf sub_conf = 3'd1;
    localparam iexu_conf and_conf = 3'd2;
    localparam iexu_conf or_conf  = 3'd3;
    localparam iexu_conf xor_conf = 3'd4;
    localparam iexu_conf sll_conf = 3'd5;
    localparam iexu_conf srl_conf = 3'd6;
    localparam iexu_conf sra_conf = 3'd7;
endpackage

module iexu_dispatch #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_instr,
    input  logic [XLEN-1:0]          in_rs1_val,
    input  logic [XLEN-1:0]          in_rs2_val,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output constants::iexu_conf      out_conf,
    output logic [XLEN-1:0]          out_op_a,
    output logic [XLEN-1:0]          out_op_b,
    output logic [4:0]               out_rd,
    output logic                     illegal,
    output logic [$clog2(DEPTH):0]   count
);
    import constants::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [6:0] OPC_OP  = 7'b0110011;
    localparam logic [6:0] OPC_IMM = 7'b0010011;
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    iexu_conf        r_conf [DEPTH];
    logic [XLEN-1:0] r_op_a [DEPTH];
    logic [XLEN-1:0] r_op_b [DEPTH];
    logic [4:0]      r_rd   [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic            r_illegal;
    logic            r_live;

    logic [6:0]      w_opc;
    logic [6:0]      w_f7;
    logic [2:0]      w_f3;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_shamt;
    logic            w_legal;
    iexu_conf        w_conf;
    logic [XLEN-1:0] w_op_b;
    logic            w_in_ready;
    logic            w_out_valid;
    logic            w_accept;
    logic            w_push;
    logic            w_pop;

    assign w_opc   = in_instr[6:0];
    assign w_f3    = in_instr[14:12];
    assign w_f7    = in_instr[31:25];
    assign w_imm   = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
    assign w_shamt = {{(XLEN-5){1'b0}}, in_instr[24:20]};

    // r_live keeps in_ready low until the first edge after reset release
    assign w_in_ready  = r_live && (r_count < FULL_CNT) && !flush;
    assign w_out_valid = (r_count != {CW{1'b0}}) && !flush;
    assign w_accept    = in_valid && w_in_ready;
    assign w_push      = w_accept && w_legal;
    assign w_pop       = w_out_valid && out_ready;

    // Instruction decode into operation code and operand B selection
    always_comb begin
        w_legal = 1'b0;
        w_conf  = add_conf;
        w_op_b  = in_rs2_val;
        case (w_opc)
            OPC_OP: begin
                case (w_f3)
                    3'b000: begin
                        w_legal = (w_f7 == F7_BASE) || (w_f7 == F7_ALT);
                        w_conf  = (w_f7 == F7_ALT) ? sub_conf : add_conf;
                    end
                    3'b111: begin w_legal = (w_f7 == F7_BASE); w_conf = and_conf; end
                    3'b110: begin w_legal = (w_f7 == F7_BASE); w_conf = or_conf;  end
                    3'b100: begin w_legal = (w_f7 == F7_BASE); w_conf = xor_conf; end
                    3'b001: begin w_legal = (w_f7 == F7_BASE); w_conf = sll_conf; end
                    3'b101: begin
                        w_legal = (w_f7 == F7_BASE) || (w_f7 == F7_ALT);
                        w_conf  = (w_f7 == F7_ALT) ? sra_conf : srl_conf;
                    end
                    default: w_legal = 1'b0;
                endcase
            end
            OPC_IMM: begin
                w_op_b = w_imm;
                case (w_f3)
                    3'b000: begin w_legal = 1'b1; w_conf = add_conf; end
                    3'b111: begin w_legal = 1'b1; w_conf = and_conf; end
                    3'b110: begin w_legal = 1'b1; w_conf = or_conf;  end
                    3'b100: begin w_legal = 1'b1; w_conf = xor_conf; end
                    3'b001: begin
                        w_legal = (w_f7 == F7_BASE);
                        w_conf  = sll_conf;
                        w_op_b  = w_shamt;
                    end
                    3'b101: begin
                        w_legal = (w_f7 == F7_BASE) || (w_f7 == F7_ALT);
                        w_conf  = (w_f7 == F7_ALT) ? sra_conf : srl_conf;
                        w_op_b  = w_shamt;
                    end
                    default: w_legal = 1'b0;
                endcase
            end
            default: w_legal = 1'b0;
        endcase
    end

    // Queue pointers, occupancy and the illegal-instruction pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr    <= {AW{1'b0}};
            r_rptr    <= {AW{1'b0}};
            r_count   <= {CW{1'b0}};
            r_illegal <= 1'b0;
            r_live    <= 1'b0;
        end else if (flush) begin
            r_wptr    <= {AW{1'b0}};
            r_rptr    <= {AW{1'b0}};
            r_count   <= {CW{1'b0}};
            r_illegal <= 1'b0;
            r_live    <= 1'b1;
        end else begin
            r_live    <= 1'b1;
            r_illegal <= w_accept && !w_legal;
            if (w_push) r_wptr <= r_wptr + AW'(1);
            else        r_wptr <= r_wptr;
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            else        r_rptr <= r_rptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; reset restores every slot to a zeroed add
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_conf[i] <= add_conf;
                r_op_a[i] <= {XLEN{1'b0}};
                r_op_b[i] <= {XLEN{1'b0}};
                r_rd[i]   <= 5'd0;
            end
        end else if (w_push) begin
            r_conf[r_wptr] <= w_conf;
            r_op_a[r_wptr] <= in_rs1_val;
            r_op_b[r_wptr] <= w_op_b;
            r_rd[r_wptr]   <= in_instr[11:7];
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_conf  = r_conf[r_rptr];
    assign out_op_a  = r_op_a[r_rptr];
    assign out_op_b  = r_op_b[r_rptr];
    assign out_rd    = r_rd[r_rptr];
    assign illegal   = r_illegal;
    assign count     = r_count;

endmodule

// File: tb/tb_iexu_dispatch.sv
// Directed bench for iexu_dispatch: a queue-based reference model checked every
// cycle, plus hand-computed literal expectations for the key scenarios.
module tb_iexu_dispatch;
    import constants::*;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam logic [6:0] OPC  = 7'b0110011;
    localparam logic [6:0] IMMC = 7'b0010011;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            flush = 1'b0;
    logic            out_ready = 1'b0;
    logic [31:0]     in_instr = 32'd0;
    logic [XLEN-1:0] rs1 = 32'd0;
    logic [XLEN-1:0] rs2 = 32'd0;
    logic            in_ready;
    logic            out_valid;
    iexu_conf        out_conf;
    logic [XLEN-1:0] out_op_a;
    logic [XLEN-1:0] out_op_b;
    logic [4:0]      out_rd;
    logic            illegal;
    logic [CW-1:0]   count;

    iexu_dispatch #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_rs1_val(rs1), .in_rs2_val(rs2), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_conf(out_conf),
        .out_op_a(out_op_a), .out_op_b(out_op_b), .out_rd(out_rd),
        .illegal(illegal), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        iexu_conf    conf;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
    } ent_t;

    ent_t mq[$];
    bit   m_live = 1'b0;
    bit   m_illegal = 1'b0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference decode straight from the ISA rules; returns 1 when legal
    function automatic bit model_dec(input logic [31:0] ins, input logic [31:0] a,
                                     input logic [31:0] b, output ent_t e);
        iexu_conf    base [8];
        logic [6:0]  opc;
        logic [6:0]  f7;
        logic [2:0]  f3;
        bit          is_op, is_imm, shift, alt, chk_f7;
        base = '{add_conf, sll_conf, add_conf, add_conf, xor_conf, srl_conf, or_conf, and_conf};
        opc = ins[6:0];
        f7 = ins[31:25];
        f3 = ins[14:12];
        is_op = (opc == OPC);
        is_imm = (opc == IMMC);
        shift = (f3 == 3'd1) || (f3 == 3'd5);
        alt = (f7 == 7'b0100000);
        chk_f7 = is_op || shift;
        e.conf = add_conf;
        e.a = a;
        e.b = 32'd0;
        e.rd = ins[11:7];
        if (!(is_op || is_imm) || f3 == 3'd2 || f3 == 3'd3) return 1'b0;
        if (chk_f7 && !(f7 == 7'd0 || (alt && (f3 == 3'd5 || (is_op && f3 == 3'd0)))))
            return 1'b0;
        e.conf = base[f3];
        if (chk_f7 && alt) e.conf = (f3 == 3'd0) ? sub_conf : sra_conf;
        e.b = is_op ? b : (shift ? {27'd0, ins[24:20]} : {{20{ins[31]}}, ins[31:20]});
        return 1'b1;
    endfunction

    // Model state advances on every active edge, cleared by reset
    initial begin
        forever begin
            bit   rdy, acc, pop, lg;
            ent_t e;
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                m_live = 1'b0;
                m_illegal = 1'b0;
            end else begin
                rdy = m_live && (mq.size() < DEPTH) && !flush;
                acc = in_valid && rdy;
                pop = (mq.size() != 0) && !flush && out_ready;
                lg = model_dec(in_instr, rs1, rs2, e);
                if (flush) begin
                    mq.delete();
                    m_illegal = 1'b0;
                end else begin
                    if (pop) void'(mq.pop_front());
                    if (acc && lg) mq.push_back(e);
                    m_illegal = acc && !lg;
                end
                m_live = 1'b1;
            end
        end
    end

    // Cycle-by-cycle comparison on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            chk("in_ready", 32'(in_ready), 32'(rst_n && m_live && (mq.size() < DEPTH) && !flush));
            chk("out_valid", 32'(out_valid), 32'(rst_n && (mq.size() != 0) && !flush));
            chk("count", 32'(count), 32'(mq.size()));
            chk("illegal", 32'(illegal), 32'(m_illegal));
            if (rst_n && !flush && mq.size() != 0) begin
                chk("head_conf", 32'(out_conf), 32'(mq[0].conf));
                chk("head_op_a", out_op_a, mq[0].a);
                chk("head_op_b", out_op_b, mq[0].b);
                chk("head_rd", 32'(out_rd), 32'(mq[0].rd));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic set_in(input logic v, input logic [31:0] ins, input logic [31:0] a,
                          input logic [31:0] b, input logic ordy, input logic fl);
        in_valid = v;
        in_instr = ins;
        rs1 = a;
        rs2 = b;
        out_ready = ordy;
        flush = fl;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] r_ins(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, 5'd2, 5'd1, f3, rd, OPC};
    endfunction

    logic [6:0]  op_f7 [8] = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h20};
    logic [2:0]  op_f3 [8] = '{3'd0, 3'd0, 3'd7, 3'd6, 3'd4, 3'd1, 3'd5, 3'd5};
    logic [31:0] imm_list [7] = '{
        {7'h00, 5'd31, 5'd1, 3'b001, 5'd5, IMMC},
        {7'h00, 5'd4, 5'd1, 3'b101, 5'd6, IMMC},
        {12'h800, 5'd1, 3'b111, 5'd7, IMMC},
        {12'h7FF, 5'd1, 3'b110, 5'd8, IMMC},
        {12'hA5A, 5'd1, 3'b100, 5'd9, IMMC},
        {7'h20, 5'd1, 5'd1, 3'b001, 5'd1, IMMC},
        {7'h01, 5'd2, 5'd1, 3'b000, 5'd1, OPC}
    };

    initial begin
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_conf", 32'(out_conf), 32'(add_conf));
        chk("rst_op_a", out_op_a, 32'd0);
        chk("rst_rd", 32'(out_rd), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("live_in_ready", 32'(in_ready), 32'd1);

        // add x3,x1,x2
        set_in(1'b1, 32'h002081B3, 32'd5, 32'd7, 1'b1, 1'b0);
        step();
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_conf", 32'(out_conf), 32'(add_conf));
        chk("add_op_a", out_op_a, 32'd5);
        chk("add_op_b", out_op_b, 32'd7);
        chk("add_rd", 32'(out_rd), 32'd3);
        set_in(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        step();
        chk("add_drained", 32'(count), 32'd0);

        // addi x1,x0,-1 then srai x2,x1,3
        set_in(1'b1, 32'hFFF00093, 32'd10, 32'd0, 1'b1, 1'b0);
        step();
        chk("addi_conf", 32'(out_conf), 32'(add_conf));
        chk("addi_op_b", out_op_b, 32'hFFFFFFFF);
        set_in(1'b1, 32'h4030D113, 32'hFFFFFFFF, 32'd0, 1'b1, 1'b0);
        step();
        chk("srai_conf", 32'(out_conf), 32'(sra_conf));
        chk("srai_op_b", out_op_b, 32'd3);
        chk("srai_rd", 32'(out_rd), 32'd2);

        // every legal OP f3/f7 pair, back to back
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, r_ins(op_f7[i], op_f3[i], 5'(i + 1)), 32'(i * 3 + 1), 32'h80000000 >> i, 1'b1, 1'b0);
            step();
        end
        chk("sra_last_conf", 32'(out_conf), 32'(sra_conf));
        chk("sra_last_op_b", out_op_b, 32'h01000000);
        for (int i = 0; i < 7; i++) begin
            set_in(1'b1, imm_list[i], 32'(i + 100), 32'hDEAD0000, 1'b1, 1'b0);
            step();
        end
        set_in(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        step();

        // illegal: slt and a JAL opcode
        set_in(1'b1, 32'h0020A1B3, 32'd1, 32'd2, 1'b1, 1'b0);
        step();
        chk("slt_illegal", 32'(illegal), 32'd1);
        chk("slt_count", 32'(count), 32'd0);
        set_in(1'b1, 32'h0000006F, 32'd1, 32'd2, 1'b1, 1'b0);
        step();
        chk("jal_illegal", 32'(illegal), 32'd1);
        chk("jal_out_valid", 32'(out_valid), 32'd0);
        set_in(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        step();
        chk("illegal_clear", 32'(illegal), 32'd0);

        // back-pressure: third instruction waits for the first pop
        set_in(1'b1, r_ins(7'h00, 3'd0, 5'd10), 32'd1, 32'd1, 1'b0, 1'b0);
        step();
        set_in(1'b1, r_ins(7'h00, 3'd7, 5'd11), 32'd2, 32'd2, 1'b0, 1'b0);
        step();
        set_in(1'b1, r_ins(7'h00, 3'd6, 5'd12), 32'd3, 32'd3, 1'b0, 1'b0);
        step();
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_count", 32'(count), 32'd2);
        chk("bp_head_rd", 32'(out_rd), 32'd10);
        step();
        chk("bp_hold_rd", 32'(out_rd), 32'd10);
        out_ready = 1'b1;
        step();
        chk("bp_pop1_count", 32'(count), 32'd1);
        chk("bp_pop1_in_ready", 32'(in_ready), 32'd1);
        chk("bp_pop1_rd", 32'(out_rd), 32'd11);
        step();
        chk("bp_third_count", 32'(count), 32'd1);
        chk("bp_third_rd", 32'(out_rd), 32'd12);
        set_in(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        step();
        chk("bp_drained", 32'(count), 32'd0);

        // flush a full queue while an illegal instruction is offered
        set_in(1'b1, r_ins(7'h00, 3'd0, 5'd13), 32'd4, 32'd4, 1'b0, 1'b0);
        step();
        set_in(1'b1, r_ins(7'h00, 3'd0, 5'd14), 32'd5, 32'd5, 1'b0, 1'b0);
        step();
        set_in(1'b1, 32'h0020A1B3, 32'd1, 32'd1, 1'b1, 1'b1);
        #1;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        step();
        set_in(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        #1;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_no_illegal", 32'(illegal), 32'd0);
        chk("flush_empty", 32'(out_valid), 32'd0);
        // flush cancels a pending illegal pulse
        set_in(1'b1, 32'h0020A1B3, 32'd1, 32'd1, 1'b0, 1'b0);
        step();
        chk("pend_illegal", 32'(illegal), 32'd1);
        set_in(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        step();
        chk("pend_cleared", 32'(illegal), 32'd0);
        set_in(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        step();

        // asynchronous reset with two entries queued
        set_in(1'b1, r_ins(7'h00, 3'd0, 5'd15), 32'd6, 32'd6, 1'b0, 1'b0);
        step();
        set_in(1'b1, r_ins(7'h00, 3'd0, 5'd16), 32'd7, 32'd7, 1'b0, 1'b0);
        step();
        set_in(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        chk("pre_rst_count", 32'(count), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        chk("arst_rd", 32'(out_rd), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        set_in(1'b1, r_ins(7'h00, 3'd4, 5'd17), 32'd8, 32'd9, 1'b1, 1'b0);
        step();
        chk("post_rst_rd", 32'(out_rd), 32'd17);
        chk("post_rst_conf", 32'(out_conf), 32'(xor_conf));
        set_in(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        step();
        chk("post_rst_drained", 32'(count), 32'd0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
